// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared types for the RV32I pipeline hazard sequencer: the FSM
//            state encoding, the bundle of pipeline-buffer control strobes
//            and the load-use detection helper.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Hazard sequencer states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    // Write-enable / flush strobes for the PC and the four pipeline buffers.
    // Kept with the pipeline-register structs so that every stage sees one
    // definition of the control bundle.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_bubble;
    } pipe_ctrl_t;

    // Every strobe low: used while reset is held.
    localparam pipe_ctrl_t c_CTRL_IDLE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Every stage advances, nothing is cleared.
    localparam pipe_ctrl_t c_CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Whole pipe holds; WB receives a bubble so nothing is written twice.
    localparam pipe_ctrl_t c_CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Wrong-path instructions in IF/ID and ID/EX are squashed.
    localparam pipe_ctrl_t c_CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Front end holds, a bubble enters EX while the load moves on.
    localparam pipe_ctrl_t c_CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // True when the instruction in ID reads the register a load in EX is
    // about to produce. x0 is never a real dependency.
    function automatic logic f_load_use(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       uses_rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        logic w_hit1;
        logic w_hit2;
        w_hit1 = uses_rs1 && (rs1 == rd);
        w_hit2 = uses_rs2 && (rs2 == rd);
        return memread && (rd != 5'd0) && (w_hit1 || w_hit2);
    endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with enable that sticks at all-ones instead of
//            wrapping. Asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding once the maximum value is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage RV32I pipeline. Resolves
//            load-use, EX redirect and data-memory wait hazards, raises a
//            sticky error on memory timeout, and counts stall cycles and
//            redirect flushes.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             exmem_memreq,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int                  c_WCNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_ONE = c_WCNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_MAX = c_WCNT_W'(MEM_TIMEOUT);

    hz_state_t           r_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_mem_err;

    logic       w_load_use;
    logic       w_mem_stall;
    logic       w_redirect_apply;
    pipe_ctrl_t w_ctrl;

    assign w_load_use  = f_load_use(idex_memread, idex_rd, id_rs1, id_uses_rs1,
                                    id_rs2, id_uses_rs2);
    assign w_mem_stall = exmem_memreq && !dmem_ready;

    // Pick the control bundle by priority: freeze > redirect > load-use > normal.
    always_comb begin
        w_ctrl           = c_CTRL_NORMAL;
        w_redirect_apply = 1'b0;
        if (reset) begin
            w_ctrl = c_CTRL_IDLE;
        end else if (r_state == ERR) begin
            w_ctrl = c_CTRL_FREEZE;
        end else if (w_mem_stall) begin
            // EX is held, so a pending redirect is seen again on release.
            w_ctrl = c_CTRL_FREEZE;
        end else if (ex_redirect) begin
            w_ctrl           = c_CTRL_REDIRECT;
            w_redirect_apply = 1'b1;
        end else if (w_load_use) begin
            w_ctrl = c_CTRL_LOADUSE;
        end
    end

    // Memory-wait sequencer with timeout and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= c_WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_MAX) begin
                        r_state   <= ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                end
                ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Stall cycles are those where the PC does not advance.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (!w_ctrl.pc_we),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (w_redirect_apply),
        .count (flush_cnt)
    );

    assign pc_we        = w_ctrl.pc_we;
    assign ifid_we      = w_ctrl.ifid_we;
    assign ifid_flush   = w_ctrl.ifid_flush;
    assign idex_we      = w_ctrl.idex_we;
    assign idex_flush   = w_ctrl.idex_flush;
    assign exmem_we     = w_ctrl.exmem_we;
    assign memwb_bubble = w_ctrl.memwb_bubble;
    assign mem_err      = r_mem_err;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl
//            (MEM_TIMEOUT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_TO = 4;
    localparam int c_CW = 4;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble}
    localparam logic [6:0] c_IDLE   = 7'b000_0000;
    localparam logic [6:0] c_NORM   = 7'b110_1010;
    localparam logic [6:0] c_FRZ    = 7'b000_0001;
    localparam logic [6:0] c_REDIR  = 7'b111_1110;
    localparam logic [6:0] c_LU     = 7'b000_1110;

    logic            clk;
    logic            reset;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic            idex_memread;
    logic [4:0]      idex_rd;
    logic            ex_redirect;
    logic            exmem_memreq;
    logic            dmem_ready;
    logic            pc_we;
    logic            ifid_we;
    logic            ifid_flush;
    logic            idex_we;
    logic            idex_flush;
    logic            exmem_we;
    logic            memwb_bubble;
    logic            mem_err;
    logic [c_CW-1:0] stall_cnt;
    logic [c_CW-1:0] flush_cnt;
    logic [6:0]      w_ctrl;

    int n_checks;
    int n_errors;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (c_TO),
        .CNT_W       (c_CW)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .ex_redirect  (ex_redirect),
        .exmem_memreq (exmem_memreq),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_we      (idex_we),
        .idex_flush   (idex_flush),
        .exmem_we     (exmem_we),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign w_ctrl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        idex_memread = 1'b0;
        idex_rd      = 5'd0;
        ex_redirect  = 1'b0;
        exmem_memreq = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clear_inputs();
        #2;
        chk("reset_ctrl", 32'(w_ctrl), 32'(c_IDLE));
        chk("reset_err", 32'(mem_err), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        chk("reset_flush", 32'(flush_cnt), 32'd0);
        tick();
        reset = 1'b0;
        #1;

        // Idle pipe advances normally.
        chk("normal_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();
        chk("normal_stall", 32'(stall_cnt), 32'd0);

        // lw x5 in EX, add reading x5 in ID: one bubble.
        idex_memread = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        chk("lu_rs1_ctrl", 32'(w_ctrl), 32'(c_LU));
        tick();
        chk("lu_rs1_stall", 32'(stall_cnt), 32'd1);
        idex_memread = 1'b0;
        #1;
        chk("lu_after_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();

        // Load targeting x0 is not a dependency.
        idex_memread = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        chk("lu_x0_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();
        chk("lu_x0_stall", 32'(stall_cnt), 32'd1);

        // Dependency through rs2.
        idex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
        #1;
        chk("lu_rs2_ctrl", 32'(w_ctrl), 32'(c_LU));
        tick();
        chk("lu_rs2_stall", 32'(stall_cnt), 32'd2);

        // Matching register that is not actually read.
        id_uses_rs2 = 1'b0;
        #1;
        chk("lu_unused_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();

        // Redirect wins over a coincident load-use.
        id_uses_rs2 = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("redir_lu_ctrl", 32'(w_ctrl), 32'(c_REDIR));
        tick();
        chk("redir_lu_flush", 32'(flush_cnt), 32'd1);
        chk("redir_lu_stall", 32'(stall_cnt), 32'd2);
        clear_inputs();

        // Three-cycle memory wait.
        exmem_memreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mwait_ctrl", 32'(w_ctrl), 32'(c_FRZ));
            tick();
        end
        chk("mwait_stall", 32'(stall_cnt), 32'd5);
        dmem_ready = 1'b1;
        #1;
        chk("mwait_release_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();
        chk("mwait_release_stall", 32'(stall_cnt), 32'd5);
        clear_inputs();

        // Redirect held through a two-cycle wait is applied on release only.
        exmem_memreq = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wredir_frozen_ctrl", 32'(w_ctrl), 32'(c_FRZ));
            tick();
        end
        chk("wredir_frozen_flush", 32'(flush_cnt), 32'd1);
        chk("wredir_frozen_stall", 32'(stall_cnt), 32'd7);
        dmem_ready = 1'b1;
        #1;
        chk("wredir_release_ctrl", 32'(w_ctrl), 32'(c_REDIR));
        tick();
        chk("wredir_release_flush", 32'(flush_cnt), 32'd2);
        clear_inputs();

        // Ready without a request changes nothing.
        dmem_ready = 1'b1;
        #1;
        chk("ready_noreq_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();
        chk("ready_noreq_stall", 32'(stall_cnt), 32'd7);
        clear_inputs();

        // Timeout: ready never comes; error after the fifth stall cycle.
        exmem_memreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to_wait_ctrl", 32'(w_ctrl), 32'(c_FRZ));
            chk("to_wait_err", 32'(mem_err), 32'd0);
            tick();
        end
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_stall", 32'(stall_cnt), 32'd12);
        exmem_memreq = 1'b0; dmem_ready = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("err_hold_ctrl", 32'(w_ctrl), 32'(c_FRZ));
        tick();
        chk("err_hold_err", 32'(mem_err), 32'd1);
        chk("err_hold_stall", 32'(stall_cnt), 32'd13);
        chk("err_hold_flush", 32'(flush_cnt), 32'd2);

        // Asynchronous reset out of ERR.
        reset = 1'b1;
        #1;
        chk("err_reset_ctrl", 32'(w_ctrl), 32'(c_IDLE));
        chk("err_reset_err", 32'(mem_err), 32'd0);
        chk("err_reset_stall", 32'(stall_cnt), 32'd0);
        chk("err_reset_flush", 32'(flush_cnt), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        exmem_memreq = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("post_reset_ctrl", 32'(w_ctrl), 32'(c_NORM));
        tick();
        clear_inputs();

        // Stall counter saturates at 15 over 20 stall cycles.
        idex_memread = 1'b1; idex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_stall_reach", 32'(stall_cnt), 32'd15);
        end
        chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
        clear_inputs();

        // Flush counter saturates as well.
        ex_redirect = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("sat_flush_hold", 32'(flush_cnt), 32'd15);
        chk("sat_flush_stall", 32'(stall_cnt), 32'd15);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives write-enables and flush/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers and the PC.
- Resolves three hazard sources: load-use, taken branch/jump, and multi-cycle data-memory wait.
- Adds a memory-wait timeout with a sticky error, plus stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before the error is raised (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in IF/ID
- id_rs2  in  5  rs2 of the instruction in IF/ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- idex_memread  in  1  MemRead field of ID/EX
- idex_rd  in  5  rd field of ID/EX
- ex_redirect  in  1  taken branch or jump resolved in EX
- exmem_memreq  in  1  MemRead or MemWrite of EX/MEM
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_we  out  1  ID/EX load enable
- idex_flush  out  1  load a bubble into ID/EX (all control bits 0)
- exmem_we  out  1  EX/MEM load enable
- memwb_bubble  out  1  load a bubble into MEM/WB (RegWrite=0)
- mem_err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  cycles with pc_we=0
- flush_cnt  out  CNT_W  number of redirect flushes applied

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset (async) → RUN; wait counter = 0; mem_err = 0; both perf counters = 0.
- Control outputs are combinational from state and inputs.
- Values during reset: pc_we=ifid_we=idex_we=exmem_we=0, all flush/bubble outputs = 0.
- load_use = idex_memread & (idex_rd≠0) & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
- mem_stall = exmem_memreq & ~dmem_ready, evaluated in RUN and MEM_WAIT.
- Priority is freeze > redirect > load-use > normal.
- Freeze (mem_stall in RUN or MEM_WAIT):
  - All *_we = 0; memwb_bubble = 1; no flushes.
  - ex_redirect is ignored while frozen. EX holds, so ex_redirect is re-seen on release and acted on then.
- Redirect (not frozen, ex_redirect = 1):
  - All we = 1; ifid_flush = 1; idex_flush = 1.
  - Any coincident load-use is discarded.
  - flush_cnt += 1.
- Load-use (not frozen, no redirect):
  - pc_we = ifid_we = 0; idex_we = 1 with idex_flush = 1; exmem_we = 1.
  - Lasts exactly one cycle, because the load then advances out of ID/EX.
- Normal: all we = 1, no flush/bubble.
- Transitions:
  - RUN→MEM_WAIT when mem_stall. The wait counter is set to 1 on that edge.
  - MEM_WAIT→RUN when dmem_ready. The release cycle applies the normal/redirect/load-use rules, and the counter clears.
  - MEM_WAIT: the counter increments each cycle. When counter == MEM_TIMEOUT and still not ready → ERR.
  - ERR: all we = 0, memwb_bubble = 1, mem_err = 1. Held until reset.
- stall_cnt increments in every post-reset cycle where pc_we = 0, including ERR.
- Both counters saturate at all-ones; they do not wrap.
- dmem_ready with exmem_memreq = 0 is ignored.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately and clears all state.

Decomposition:
- Shared package: state enum (RUN/MEM_WAIT/ERR) and a packed struct pipe_ctrl_t grouping pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble. The struct lives beside the existing pipeline-register structs.
- One natural sub-module, sat_counter (parameterised width, enable, async reset), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: lw x5 in ID/EX (idex_memread=1, idex_rd=5); ID add with id_rs1=5 → exactly one cycle with pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1. Repeat with idex_rd=0 → no stall.
- Redirect + load-use same cycle: ex_redirect=1 and load_use=1 → ifid_flush=1, idex_flush=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: exmem_memreq=1, dmem_ready low for 3 cycles then high → 3 cycles with all we=0 and memwb_bubble=1; state MEM_WAIT then RUN; stall_cnt=3.
- Redirect during wait: ex_redirect held high through a 2-cycle wait → no flush while frozen; flush on the release cycle; flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready never high → mem_err=1 after the 5th stall cycle; outputs stay frozen; assert reset → mem_err=0, counters=0, state RUN.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt=15 and holds at 15.
